display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Upstream driver for the 3-bit seven-segment decoder. Holds a frame of NUM_DIGITS digit values and time-multiplexes them onto one shared digit bus (digit_code → decoder dataIN) with active-low anode selects.
- New frames arrive through a valid/ready load port. They are double-buffered and swapped only at frame boundaries, so the display never shows a torn frame.
- Each digit slot begins with an anode-off guard interval, which prevents ghosting while the decoder output settles.

Parameters:
- DATA_WIDTH, 3: bits per digit; matches the decoder input width.
- NUM_DIGITS, 4: number of multiplexed digits; ≥ 2.
- PRESCALE, 50000: clock cycles per digit slot; ≥ 2.
- BLANK_CYCLES, 1000: guard cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < PRESCALE.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- load_valid, input, 1: load_data is valid.
- load_ready, output, 1: a pending slot is free to accept a frame.
- load_data, input, NUM_DIGITS*DATA_WIDTH: frame. Digit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- digit_en, input, NUM_DIGITS: per-digit anode enable. Level input, sampled every cycle.
- digit_code, output, DATA_WIDTH: value of the current slot's digit; drives decoder dataIN.
- anode_n, output, NUM_DIGITS: active-low anode selects; at most one bit low at a time.
- digit_sel, output, clog2(NUM_DIGITS): index of the current slot.
- frame_done, output, 1: one-cycle pulse on the last cycle of slot NUM_DIGITS-1.

Behaviour:
- Reset (async assert, sync-safe release):
  - slot counter = 0, digit_sel = 0, state = BLANK.
  - Active and pending frames = 0; pending_valid = 0.
  - anode_n = all ones, digit_code = 0, frame_done = 0, load_ready = 1.
  - Reset mid-slot forces anode_n high in the same instant (async). A pending frame is discarded.
- Slot timer:
  - cnt runs 0..PRESCALE-1 and wraps to 0.
  - On wrap, digit_sel increments, going from NUM_DIGITS-1 back to 0.
- State machine, per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt ≥ BLANK_CYCLES.
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK on slot wrap.
- Outputs (all registered):
  - BLANK: anode_n = all ones.
  - SHOW: anode_n[digit_sel] = ~digit_en[digit_sel]; all other bits = 1.
  - digit_code = active[digit_sel]. It updates on the first cycle of the slot, during BLANK.
  - After reset release, cycles 0..BLANK_CYCLES-1 have anodes off. Cycles BLANK_CYCLES..PRESCALE-1 have anode 0 low.
- Load handshake:
  - Transfer occurs when load_valid && load_ready.
  - load_ready = ~pending_valid, driven from a register with no combinational path from load_valid.
  - An accepted frame goes to pending and sets pending_valid.
  - Sender must hold load_data stable while valid && !ready.
- Frame boundary (cnt == PRESCALE-1 && digit_sel == NUM_DIGITS-1):
  - frame_done = 1 for that cycle.
  - If pending_valid: active ← pending and pending_valid ← 0. load_ready rises the next cycle.
  - The new frame is visible from slot 0 of the next frame.
- Simultaneous accept and boundary: possible only when pending was empty. The frame is captured into pending and swaps at the following boundary, not this one.
- digit_en changes take effect on the next cycle. Disabled digits still sequence digit_sel and digit_code.
- Width rules:
  - cnt is clog2(PRESCALE) bits.
  - digit_sel is clog2(NUM_DIGITS) bits, with an explicit wrap compare. NUM_DIGITS need not be a power of two.

Decomposition:
- Shared package display_pkg holds:
  - DIGIT_W = 3.
  - Function clog2.
  - Enum scan_state_t {BLANK, SHOW}.
  - Constant ANODE_OFF = all ones.
- One sub-module, slot_timer (params PRESCALE, BLANK_CYCLES). It outputs cnt, slot_wrap, and in_blank. Frame buffering and output muxing stay in display_scan_mux.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, digit_en=4'b1111 unless stated):
- Reset, then release → anode_n=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles, then 1111×2, 1101×6, and so on. digit_code=0 throughout. frame_done pulses once every 32 cycles, on cycle 31.
- Pulse load_valid at cycle 5 with digits {7,5,2,1} (digit3..0) → accepted (ready=1); load_ready=0 from cycle 6 until the cycle after frame_done. In the second frame, digit_code sequences 1,2,5,7 across slots 0..3.
- Second load {3,3,3,3} held valid while ready=0 → no accept until after the boundary. The displayed frame is never a mix of old and new digits. {3,3,3,3} appears one frame after it is accepted.
- digit_en=4'b0101 → anode_n bits 1 and 3 never go low. digit_sel and digit_code still step through 0..3.
- Load asserted exactly on the frame_done cycle with pending empty → accepted. The active frame is unchanged in the next frame; the new frame appears one frame later.
- Assert rst at cycle 13 (mid-SHOW of slot 1) → anode_n=4'b1111 immediately, pending dropped, load_ready=1. After release, scanning restarts at slot 0 with active digits = 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package display_pkg;
    localparam int DIGIT_W = 3;
    localparam logic [31:0] ANODE_OFF = '1;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    // Minimum 1 so single-valued counters still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/display_scan_mux_slot_timer.sv
// Per-slot cycle counter: runs 0..PRESCALE-1 and flags the wrap and guard interval.
module slot_timer
    import display_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [clog2(PRESCALE)-1:0] cnt,
    output logic                       slot_wrap,
    output logic                       in_blank
);
    localparam int CNT_W = clog2(PRESCALE);

    assign slot_wrap = (cnt == CNT_W'(PRESCALE - 1));
    assign in_blank  = (cnt < CNT_W'(BLANK_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/display_scan_mux.sv
// Double-buffered frame store time-multiplexed onto one digit bus with
// active-low anode selects and an anode-off guard at the start of each slot.
//
// state | meaning
// BLANK | guard interval, all anodes off while the decoder settles
// SHOW  | current slot's anode driven from digit_en
module display_scan_mux
    import display_pkg::*;
#(
    parameter int DATA_WIDTH   = DIGIT_W,
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]            digit_en,
    output logic [DATA_WIDTH-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]            anode_n,
    output logic [clog2(NUM_DIGITS)-1:0]     digit_sel,
    output logic                             frame_done
);
    localparam int SEL_W   = clog2(NUM_DIGITS);
    localparam int CNT_W   = clog2(PRESCALE);
    localparam int FRAME_W = NUM_DIGITS * DATA_WIDTH;
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]      cnt;
    logic                  slot_wrap;
    logic                  in_blank;
    scan_state_t           state;
    logic [FRAME_W-1:0]    active_frame;
    logic [FRAME_W-1:0]    pending_frame;
    logic                  pending_valid;
    logic                  sel_last;
    logic [SEL_W-1:0]      sel_next;
    logic                  frame_end;
    logic                  swap;
    logic                  accept;
    logic                  blank_end;
    logic [NUM_DIGITS-1:0] show_anode;
    logic [DATA_WIDTH-1:0] next_code;

    slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .slot_wrap (slot_wrap),
        .in_blank  (in_blank)
    );

    assign load_ready = ~pending_valid;
    assign sel_last   = (digit_sel == SEL_W'(NUM_DIGITS - 1));
    assign sel_next   = sel_last ? '0 : digit_sel + SEL_W'(1);
    assign frame_end  = slot_wrap && sel_last;
    assign swap       = frame_end && pending_valid;
    assign accept     = load_valid && load_ready;
    assign blank_end  = in_blank && (cnt == CNT_W'(BLANK_CYCLES - 1));

    // The code register loads at the slot wrap, so slot 0 of a new frame must
    // read straight from the pending buffer being swapped in on that same edge.
    always_comb begin
        show_anode = ALL_OFF;
        show_anode[digit_sel] = ~digit_en[digit_sel];
        if (swap) begin
            next_code = pending_frame[DATA_WIDTH-1:0];
        end else begin
            next_code = active_frame[int'(sel_next)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BLANK;
            digit_sel     <= '0;
            anode_n       <= ALL_OFF;
            digit_code    <= '0;
            frame_done    <= 1'b0;
            active_frame  <= '0;
            pending_frame <= '0;
            pending_valid <= 1'b0;
        end else begin
            frame_done <= (cnt == CNT_W'(PRESCALE - 2)) && sel_last;

            // accept and swap are exclusive: accept needs an empty pending slot
            if (accept) begin
                pending_frame <= load_data;
                pending_valid <= 1'b1;
            end else if (swap) begin
                pending_valid <= 1'b0;
            end
            if (swap) begin
                active_frame <= pending_frame;
            end

            case (state)
                BLANK: begin
                    anode_n <= ALL_OFF;
                    if (blank_end) begin
                        state   <= SHOW;
                        anode_n <= show_anode;
                    end
                end
                SHOW: begin
                    if (slot_wrap) begin
                        state   <= BLANK;
                        anode_n <= ALL_OFF;
                    end else begin
                        anode_n <= show_anode;
                    end
                end
                default: begin
                    state   <= BLANK;
                    anode_n <= ALL_OFF;
                end
            endcase

            if (slot_wrap) begin
                digit_sel  <= sel_next;
                digit_code <= next_code;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_display_scan_mux;
    localparam int DW = 3;
    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [ND*DW-1:0] load_data;
    logic [ND-1:0]    digit_en;
    logic [DW-1:0]    digit_code;
    logic [ND-1:0]    anode_n;
    logic [1:0]       digit_sel;
    logic             frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_scan_mux #(
        .DATA_WIDTH   (DW),
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_en   (digit_en),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    // Expected anode pattern for cycle c after reset release.
    function automatic logic [3:0] exp_anode(input int c, input logic [3:0] en);
        int s;
        logic [3:0] a;
        s = (c / PS) % ND;
        a = 4'b1111;
        if ((c % PS) >= BC) a[s] = ~en[s];
        return a;
    endfunction

    function automatic logic [2:0] digit_of(input logic [11:0] f, input int s);
        return f[s*DW +: DW];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        digit_en = 4'b1111;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b want 1111", anode_n); end
        n_cmp++; if (digit_code !== 3'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", digit_code); end
        n_cmp++; if (digit_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", digit_sel); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        rst = 1'b0;
    endtask

    // Follows test_reset directly: sampling point is mid-cycle 0.
    task automatic test_scan();
        logic [1:0] es;
        for (int k = 0; k < 64; k++) begin
            es = 2'((k / PS) % ND);
            n_cmp++; if (anode_n !== exp_anode(k, 4'b1111)) begin n_bad++; $display("FAIL scan_anode c%0d: got %b want %b", k, anode_n, exp_anode(k, 4'b1111)); end
            n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL scan_sel c%0d: got %0d want %0d", k, digit_sel, es); end
            n_cmp++; if (digit_code !== 3'd0) begin n_bad++; $display("FAIL scan_code c%0d: got %0d want 0", k, digit_code); end
            n_cmp++; if (frame_done !== (k % 32 == 31)) begin n_bad++; $display("FAIL scan_frame_done c%0d: got %b want %b", k, frame_done, (k % 32 == 31)); end
            @(negedge clk);
        end
    endtask

    // Pulse load A at cycle 5, then hold B from cycle 10 until it is accepted.
    task automatic test_load_hold();
        logic [11:0] fa;
        logic [11:0] fb;
        logic [11:0] ef;
        logic        er;
        fa = 12'o7521;
        fb = 12'o3333;
        digit_en = 4'b1111;
        apply_reset();
        for (int k = 0; k < 96; k++) begin
            if (k == 5)  begin load_valid = 1'b1; load_data = fa; end
            if (k == 6)  load_valid = 1'b0;
            if (k == 10) begin load_valid = 1'b1; load_data = fb; end
            if (k == 33) load_valid = 1'b0;
            er = !((k >= 6 && k <= 31) || (k >= 33 && k <= 63));
            ef = (k < 32) ? 12'o0000 : (k < 64) ? fa : fb;
            n_cmp++; if (load_ready !== er) begin n_bad++; $display("FAIL load_ready c%0d: got %b want %b", k, load_ready, er); end
            n_cmp++; if (digit_code !== digit_of(ef, (k / PS) % ND)) begin n_bad++; $display("FAIL load_code c%0d: got %0d want %0d", k, digit_code, digit_of(ef, (k / PS) % ND)); end
            n_cmp++; if (anode_n !== exp_anode(k, 4'b1111)) begin n_bad++; $display("FAIL load_anode c%0d: got %b want %b", k, anode_n, exp_anode(k, 4'b1111)); end
            @(negedge clk);
        end
    endtask

    // Disabled digits keep sequencing; digit_en change lands one cycle later.
    task automatic test_digit_en();
        logic [11:0] fc;
        logic [3:0]  en_eff;
        logic [1:0]  es;
        fc = 12'o3210;
        digit_en = 4'b0101;
        apply_reset();
        load_valid = 1'b1;
        load_data = fc;
        for (int k = 0; k < 64; k++) begin
            if (k == 1)  load_valid = 1'b0;
            if (k == 44) digit_en = 4'b1111;
            en_eff = (k >= 45) ? 4'b1111 : 4'b0101;
            es = 2'((k / PS) % ND);
            n_cmp++; if (anode_n !== exp_anode(k, en_eff)) begin n_bad++; $display("FAIL en_anode c%0d: got %b want %b", k, anode_n, exp_anode(k, en_eff)); end
            n_cmp++; if (digit_sel !== es) begin n_bad++; $display("FAIL en_sel c%0d: got %0d want %0d", k, digit_sel, es); end
            if (k >= 32) begin
                n_cmp++; if (digit_code !== 3'(es)) begin n_bad++; $display("FAIL en_code c%0d: got %0d want %0d", k, digit_code, es); end
            end
            @(negedge clk);
        end
    endtask

    // Load accepted on the frame_done cycle swaps at the following boundary.
    task automatic test_load_on_boundary();
        logic [11:0] fd;
        logic [11:0] ef;
        logic        er;
        fd = 12'o4615;
        digit_en = 4'b1111;
        apply_reset();
        for (int k = 0; k < 96; k++) begin
            if (k == 31) begin load_valid = 1'b1; load_data = fd; end
            if (k == 32) load_valid = 1'b0;
            er = !(k >= 32 && k <= 63);
            ef = (k < 64) ? 12'o0000 : fd;
            n_cmp++; if (load_ready !== er) begin n_bad++; $display("FAIL bnd_ready c%0d: got %b want %b", k, load_ready, er); end
            n_cmp++; if (frame_done !== (k % 32 == 31)) begin n_bad++; $display("FAIL bnd_frame_done c%0d: got %b want %b", k, frame_done, (k % 32 == 31)); end
            n_cmp++; if (digit_code !== digit_of(ef, (k / PS) % ND)) begin n_bad++; $display("FAIL bnd_code c%0d: got %0d want %0d", k, digit_code, digit_of(ef, (k / PS) % ND)); end
            @(negedge clk);
        end
    endtask

    // Reset in mid-SHOW of slot 1 with a frame pending.
    task automatic test_reset_mid();
        digit_en = 4'b1111;
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            if (k == 5) begin load_valid = 1'b1; load_data = 12'o7777; end
            if (k == 6) load_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (anode_n !== 4'b1101) begin n_bad++; $display("FAIL mid_pre_anode: got %b want 1101", anode_n); end
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pre_ready: got %b want 0", load_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL mid_async_anode: got %b want 1111", anode_n); end
        n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL mid_async_ready: got %b want 1", load_ready); end
        n_cmp++; if (digit_sel !== 2'd0) begin n_bad++; $display("FAIL mid_async_sel: got %0d want 0", digit_sel); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            n_cmp++; if (anode_n !== exp_anode(k, 4'b1111)) begin n_bad++; $display("FAIL mid_anode c%0d: got %b want %b", k, anode_n, exp_anode(k, 4'b1111)); end
            n_cmp++; if (digit_code !== 3'd0) begin n_bad++; $display("FAIL mid_code c%0d: got %0d want 0", k, digit_code); end
            n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready c%0d: got %b want 1", k, load_ready); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_hold();
        test_digit_en();
        test_load_on_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
